// File: rtl/rx_peak_report_fifo.sv
// rtl/rx_peak_report_fifo.sv - peak report capture queue with hold-off, overflow count and FWFT read port
// Registered head-of-queue outputs; memory is unreset, pointers/count carry the reset state.
module rx_peak_report_fifo #(
    parameter int DEPTH    = 8,
    parameter int SAMPLE_W = 41,
    parameter int SEQ_W    = 4,
    parameter int TIME_W   = 16,
    parameter int HOLDOFF  = 0
) (
    input  logic                       crx_clk,
    input  logic                       rrx_rst,
    input  logic                       erx_en,
    input  logic [SAMPLE_W-1:0]        i_sample_arm,
    input  logic [SEQ_W-1:0]           i_received_seq,
    input  logic [TIME_W-1:0]          i_time_arm,
    input  logic                       i_trigger_arm,
    output logic [SAMPLE_W-1:0]        o_sample,
    output logic [SEQ_W-1:0]           o_seq,
    output logic [TIME_W-1:0]          o_time,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [7:0]                 o_ovf_cnt,
    input  logic                       i_clear_ovf,
    output logic                       o_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = SAMPLE_W + SEQ_W + TIME_W;
    // The trigger cycle itself is the first hold-off cycle, so the counter covers HOLDOFF-1 more.
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HW'(HOLDOFF - 1) : '0;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic [7:0]    ovf_q, ovf_d;
    logic [EW-1:0] head_q, head_d;
    logic          valid_q, valid_d;

    logic [EW-1:0] wr_data;
    logic          full, pop, req, wr_en, drop;

    always_comb begin
        wr_data = {i_sample_arm, i_received_seq, i_time_arm};
        full    = (count_q == CW'(DEPTH));
        pop     = valid_q & i_ready;
        req     = i_trigger_arm & erx_en & (holdoff_q == '0);
        wr_en   = req & (~full | pop);
        drop    = req & full & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        holdoff_d = holdoff_q;
        if (wr_en) begin
            holdoff_d = HOLD_LOAD;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - 1'b1;
        end

        ovf_d = ovf_q;
        if (i_clear_ovf) begin
            ovf_d = '0;
        end else if (drop && ovf_q != 8'hFF) begin
            ovf_d = ovf_q + 8'd1;
        end

        // Next head may be the entry being written this cycle (queue empty or down to one).
        head_d = head_q;
        if (count_d != '0) begin
            if (wr_en && rd_ptr_d == wr_ptr_q) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge crx_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst) begin
        if (!rrx_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            holdoff_q <= '0;
            ovf_q     <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            holdoff_q <= holdoff_d;
            ovf_q     <= ovf_d;
            head_q    <= head_d;
            valid_q   <= valid_d;
        end
    end

    assign o_sample  = head_q[EW-1 -: SAMPLE_W];
    assign o_seq     = head_q[TIME_W +: SEQ_W];
    assign o_time    = head_q[TIME_W-1:0];
    assign o_valid   = valid_q;
    assign o_irq     = valid_q;
    assign o_count   = count_q;
    assign o_ovf_cnt = ovf_q;

endmodule
